// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
package seg_pkg;

  typedef enum logic [1:0] {
    RESET,
    BLANK,
    DRIVE
  } states_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  // Active-low {g,f,e,d,c,b,a} pattern for each hex digit, index 0 first.
  localparam logic [0:15][6:0] HEX_SEG = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Hex nibble to active-low 7-segment pattern; purely combinational.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segment
);

  assign segment = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// Double-buffers the display value and commits it only at frame ends.
//
//   state | meaning
//   RESET | held in reset, all outputs off
//   BLANK | anti-ghosting gap, all anodes off
//   DRIVE | digit idx driven (unless leading-zero blanked)
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV = 100000,
  parameter int GAP_CYC  = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_data,
  input  logic [3:0]  wr_dp,
  input  logic        wr_lzb,
  output logic [6:0]  segment,
  output logic        dp,
  output logic [3:0]  anode,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);
  // Slot timers count down to zero, so the load value is the length minus one.
  localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] DRV_LOAD = CW'(TICK_DIV - GAP_CYC - 1);

  states_t       state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic          frame_end;
  logic          fd_nx;

  logic [15:0]   disp_data, shd_data;
  logic [3:0]    disp_dp, shd_dp;
  logic          disp_lzb, shd_lzb;
  logic          pending, pending_nx;
  logic          accept, commit;

  logic [3:0]    zero_nib;
  logic [3:0]    blank_mask;
  logic [3:0]    nib_sel;
  logic [6:0]    seg_dec;

  assign zero_nib[3] = (disp_data[15:12] == 4'h0);
  assign zero_nib[2] = (disp_data[11:8]  == 4'h0);
  assign zero_nib[1] = (disp_data[7:4]   == 4'h0);
  assign zero_nib[0] = (disp_data[3:0]   == 4'h0);

  // A digit is blanked only while it and every digit to its left are zero.
  assign blank_mask[3] = disp_lzb & zero_nib[3];
  assign blank_mask[2] = blank_mask[3] & zero_nib[2];
  assign blank_mask[1] = blank_mask[2] & zero_nib[1];
  assign blank_mask[0] = 1'b0;

  // Outputs are computed for the digit about to be driven, not the current one.
  assign nib_sel = disp_data[{idx_nx, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nibble  (nib_sel),
    .segment (seg_dec)
  );

  assign accept     = wr_valid & wr_ready;
  assign commit     = frame_end & pending;
  assign pending_nx = accept | (pending & ~commit);

  // Next-state, slot timer and digit index sequencing.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    frame_end = 1'b0;
    case (state)
      RESET: begin
        state_nx = BLANK;
        cnt_nx   = GAP_LOAD;
        idx_nx   = 2'd3;
      end
      BLANK: begin
        if (cnt == '0) begin
          state_nx = DRIVE;
          cnt_nx   = DRV_LOAD;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      DRIVE: begin
        if (cnt == '0) begin
          state_nx  = BLANK;
          cnt_nx    = GAP_LOAD;
          idx_nx    = idx - 2'd1;
          frame_end = (idx == 2'd0);
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = RESET;
        cnt_nx   = '0;
        idx_nx   = 2'd3;
      end
    endcase
    fd_nx = (state_nx == DRIVE) && (idx_nx == 2'd0) && (cnt_nx == '0);
  end

  // FSM state plus registered pin outputs, updated together so pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET;
      cnt        <= '0;
      idx        <= 2'd3;
      anode      <= ANODE_OFF;
      segment    <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      frame_done <= fd_nx;
      if (state_nx == DRIVE && !blank_mask[idx_nx]) begin
        anode   <= ~(4'b0001 << idx_nx);
        segment <= seg_dec;
        dp      <= ~disp_dp[idx_nx];
      end else begin
        anode   <= ANODE_OFF;
        segment <= SEG_BLANK;
        dp      <= 1'b1;
      end
    end
  end

  // Shadow/display double buffer; a commit needs pending set before the frame-end edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd_data  <= 16'h0000;
      shd_dp    <= 4'b0000;
      shd_lzb   <= 1'b0;
      disp_data <= 16'h0000;
      disp_dp   <= 4'b0000;
      disp_lzb  <= 1'b0;
      pending   <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      if (accept) begin
        shd_data <= wr_data;
        shd_dp   <= wr_dp;
        shd_lzb  <= wr_lzb;
      end
      if (commit) begin
        disp_data <= shd_data;
        disp_dp   <= shd_dp;
        disp_lzb  <= shd_lzb;
      end
      pending  <= pending_nx;
      wr_ready <= ~pending_nx;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with an 8-cycle slot and 2-cycle gap.
module tb_seg_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        wr_lzb;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  anode;
  logic        frame_done;

  int errors;
  int checks;
  int pos;

  typedef struct {
    logic [15:0]     data;
    logic [3:0]      dpv;
    logic            lzb;
    logic [3:0][6:0] segs;
    logic [3:0]      on;
    logic [3:0]      dpn;
  } vec_t;

  vec_t vecs[6];

  localparam logic [3:0][6:0] SEGS_ZERO = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};

  seg_scan_ctrl #(.TICK_DIV(8), .GAP_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_lzb     (wr_lzb),
    .segment    (segment),
    .dp         (dp),
    .anode      (anode),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (frame pos %0d, t=%0t)", name, act, exp, pos, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    pos = (pos + 1) % 32;
  endtask

  // Checks one full frame from its first blank cycle; optionally pulses
  // wr_valid for one cycle at frame position wv_at.
  task automatic check_frame(input logic [3:0][6:0] segs, input logic [3:0] on,
                             input logic [3:0] dpn, input int wv_at);
    for (int i = 0; i < 32; i++) begin
      int   slot;
      int   off;
      logic fd;
      slot = 3 - i / 8;
      off  = i % 8;
      fd   = (i == 31);
      if (off < 2)
        chk("gap", {anode, segment, dp, frame_done}, {4'hF, 7'h7F, 1'b1, fd});
      else if (!on[slot])
        chk("lzb_blank", {anode, frame_done}, {4'hF, fd});
      else
        chk("drive", {anode, segment, dp, frame_done},
            {~(4'b0001 << slot), segs[slot], dpn[slot], fd});
      if (i == wv_at) wr_valid = 1'b1;
      step();
      if (i == wv_at) begin
        wr_valid = 1'b0;
        chk("ready_drop", wr_ready, 1'b0);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pos = 0;
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = 16'h0000;
    wr_dp = 4'b0000;
    wr_lzb = 1'b0;

    vecs[0] = '{16'h1234, 4'b0010, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111, 4'b1101};
    vecs[1] = '{16'h5678, 4'b1001, 1'b0,
                {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b1111, 4'b0110};
    vecs[2] = '{16'h9DE0, 4'b0100, 1'b1,
                {7'b0010000, 7'b0100001, 7'b0000110, 7'b1000000}, 4'b1111, 4'b1011};
    vecs[3] = '{16'h0050, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, 4'b0011, 4'b1111};
    vecs[4] = '{16'h0000, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0001, 4'b1111};
    vecs[5] = '{16'h0A07, 4'b1111, 1'b1,
                {7'b1111111, 7'b0001000, 7'b1000000, 7'b1111000}, 4'b0111, 4'b0000};

    // Reset values held while rst is asserted
    repeat (3) @(negedge clk);
    chk("reset_outputs", {anode, segment, dp, wr_ready, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    pos = 31;
    step();
    chk("ready_after_reset", wr_ready, 1'b1);

    // Free-running frames showing the reset value 0000
    check_frame(SEGS_ZERO, 4'b1111, 4'b1111, -1);
    check_frame(SEGS_ZERO, 4'b1111, 4'b1111, -1);

    // Table: write mid-frame, old frame unchanged, next frame shows new value
    begin
      logic [3:0][6:0] prev_segs;
      logic [3:0]      prev_on;
      logic [3:0]      prev_dpn;
      prev_segs = SEGS_ZERO;
      prev_on   = 4'b1111;
      prev_dpn  = 4'b1111;
      for (int v = 0; v < 6; v++) begin
        wr_data = vecs[v].data;
        wr_dp   = vecs[v].dpv;
        wr_lzb  = vecs[v].lzb;
        check_frame(prev_segs, prev_on, prev_dpn, 5);
        chk("ready_after_commit", wr_ready, 1'b1);
        check_frame(vecs[v].segs, vecs[v].on, vecs[v].dpn, -1);
        prev_segs = vecs[v].segs;
        prev_on   = vecs[v].on;
        prev_dpn  = vecs[v].dpn;
      end

      // Write accepted on the frame_done cycle waits a whole extra frame
      wr_data = 16'hABCF;
      wr_dp   = 4'b0000;
      wr_lzb  = 1'b0;
      check_frame(prev_segs, prev_on, prev_dpn, 31);
      check_frame(prev_segs, prev_on, prev_dpn, -1);
      chk("ready_after_fe_commit", wr_ready, 1'b1);
      check_frame({7'b0001000, 7'b0000011, 7'b1000110, 7'b0001110}, 4'b1111, 4'b1111, -1);
    end

    // Back-pressure: wr_valid held with changing data while pending
    wr_data  = 16'h1357;
    wr_dp    = 4'b0000;
    wr_lzb   = 1'b0;
    wr_valid = 1'b1;
    step();
    chk("bp_ready_low", wr_ready, 1'b0);
    for (int i = 1; i < 32; i++) begin
      wr_data = 16'hC000 + 16'(i);
      step();
    end
    chk("bp_ready_high", wr_ready, 1'b1);
    wr_data = 16'h2468;
    check_frame({7'b1111001, 7'b0110000, 7'b0010010, 7'b1111000}, 4'b1111, 4'b1111, 0);
    chk("bp_ready_after_commit", wr_ready, 1'b1);
    check_frame({7'b0100100, 7'b0011001, 7'b0000010, 7'b0000000}, 4'b1111, 4'b1111, -1);

    // Reset mid-DRIVE with a pending write that must be discarded
    step();
    step();
    wr_data  = 16'h9999;
    wr_valid = 1'b1;
    step();
    wr_valid = 1'b0;
    step();
    chk("pre_reset_drive", {anode, segment}, {4'b0111, 7'b0100100});
    rst = 1'b1;
    #1;
    chk("async_reset", {anode, segment, dp, wr_ready, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    @(negedge clk);
    chk("reset_held", {anode, segment, dp, wr_ready, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    pos = 31;
    step();
    chk("ready_after_rereset", wr_ready, 1'b1);
    check_frame(SEGS_ZERO, 4'b1111, 4'b1111, -1);
    check_frame(SEGS_ZERO, 4'b1111, 4'b1111, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
